ifu_fetch: RTL

Instruction fetch stage of the RV64 core, directly upstream of the decoder.
- Owns the PC register and issues one instruction-memory read at a time over a valid/ready request/response bus.
- Hands each returned 32-bit instruction, with its PC, to decode through a valid/ready handshake.
- Accepts redirects (branch/jump/trap targets) from execute and discards wrong-path fetches.

---
 rtl/ifu_fetch_pkg.sv | 33 +++
 rtl/ifu_pc.sv | 42 ++++
 rtl/ifu_fetch.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC, NOP encoding, fault codes and state encodings
// for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   PC_RESET = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_ACCESS   = 2'b01,
    FAULT_MISALIGN = 2'b10
  } fault_e;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    PC_KEEP  = 2'b00,
    PC_INC   = 2'b01,
    PC_REDIR = 2'b10
  } pc_sel_e;

  function automatic logic misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_pc.sv
// PC register with next-PC selection (hold, +4, redirect), the address of a
// request that must stay on the bus after a redirect, and alignment checks.
module ifu_pc
  import ifu_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_e         pc_sel,
  input  logic            held_load,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] held_pc,
  output logic            pc_misaligned,
  output logic            target_misaligned
);

  logic [XLEN-1:0] pc_d;

  // +4 wraps modulo 2^XLEN by construction
  always_comb begin
    pc_d = pc;
    unique case (pc_sel)
      PC_INC:   pc_d = pc + XLEN'(4);
      PC_REDIR: pc_d = redirect_pc;
      default:  pc_d = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= PC_RESET;
      held_pc <= PC_RESET;
    end else begin
      pc <= pc_d;
      if (held_load) held_pc <= pc;
    end
  end

  assign pc_misaligned     = misaligned(pc[1:0]);
  assign target_misaligned = misaligned(redirect_pc[1:0]);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem read, instruction handoff to
// decode, redirect handling with wrong-path response discard.
module ifu_fetch
  import ifu_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [XLEN-1:0]   req_addr_o,
  input  logic              resp_valid_i,
  output logic              resp_ready_o,
  input  logic [INST_W-1:0] resp_data_i,
  input  logic              resp_err_i,
  input  logic              redirect_valid_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [1:0]        fault_o,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; once raised, valid and its payload hold until that transfer.

  state_e            state_q, state_d;
  logic              kill_q, kill_d;
  logic              valid_d;
  logic              out_load;
  logic [INST_W-1:0] out_inst;
  logic [XLEN-1:0]   out_pc;
  fault_e            out_fault;
  pc_sel_e           pc_sel;
  logic              held_load;
  logic [XLEN-1:0]   pc, held_pc;
  logic              pc_mis, target_mis;

  ifu_pc u_pc (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_sel            (pc_sel),
    .held_load         (held_load),
    .redirect_pc       (redirect_pc_i),
    .pc                (pc),
    .held_pc           (held_pc),
    .pc_misaligned     (pc_mis),
    .target_misaligned (target_mis)
  );

  // While killed in REQ, the unaccepted request keeps its pre-redirect address
  assign req_valid_o  = (state_q == S_REQ);
  assign req_addr_o   = (state_q == S_REQ && kill_q) ? held_pc : pc;
  assign resp_ready_o = (state_q == S_WAIT);
  assign dbg_state    = state_q;

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    valid_d   = inst_valid_o;
    out_load  = 1'b0;
    out_inst  = NOP;
    out_pc    = pc;
    out_fault = FAULT_NONE;
    pc_sel    = PC_KEEP;
    held_load = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid_i) begin
          pc_sel = PC_REDIR;
          kill_d = 1'b1;
          if (req_ready_i) state_d = S_WAIT;
          else             held_load = !kill_q;
        end else if (req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid_i) begin
          pc_sel = PC_REDIR;
          kill_d = 1'b1;
          if (resp_valid_i) begin
            kill_d = 1'b0;
            if (target_mis) begin
              state_d   = S_HOLD;
              valid_d   = 1'b1;
              out_load  = 1'b1;
              out_pc    = redirect_pc_i;
              out_fault = FAULT_MISALIGN;
            end else begin
              state_d = S_REQ;
            end
          end
        end else if (resp_valid_i) begin
          if (kill_q) begin
            // Wrong-path response retires; a pending misaligned target faults now
            kill_d = 1'b0;
            if (pc_mis) begin
              state_d   = S_HOLD;
              valid_d   = 1'b1;
              out_load  = 1'b1;
              out_fault = FAULT_MISALIGN;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            state_d   = S_HOLD;
            valid_d   = 1'b1;
            out_load  = 1'b1;
            out_inst  = resp_data_i;
            out_fault = resp_err_i ? FAULT_ACCESS : FAULT_NONE;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid_i) begin
          pc_sel = PC_REDIR;
          if (target_mis) begin
            valid_d   = 1'b1;
            out_load  = 1'b1;
            out_pc    = redirect_pc_i;
            out_fault = FAULT_MISALIGN;
          end else begin
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end else if (inst_ready_i) begin
          valid_d = 1'b0;
          pc_sel  = PC_INC;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
        kill_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      kill_q       <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_o       <= NOP;
      pc_o         <= '0;
      fault_o      <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      inst_valid_o <= valid_d;
      if (out_load) begin
        inst_o  <= out_inst;
        pc_o    <= out_pc;
        fault_o <= out_fault;
      end
    end
  end

endmodule
